// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared constants for the traffic-light timing path.
//            DIV_SIM / DIV_BOARD select the prescaler divisor for simulation
//            and board builds; DIV_WIDTH must hold DIV_BOARD.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam int unsigned DIV_SIM        = 10;
  localparam int unsigned DIV_BOARD      = 100_000_000;
  localparam int          DIV_WIDTH      = 27;
  localparam int          TICK_CNT_WIDTH = 8;

endpackage : traffic_pkg

`default_nettype wire

// File: rtl/enable_generator.sv
// ============================================================================
// Module   : enable_generator
// Purpose  : Runtime-programmable prescaler. Emits a one-cycle enable_tick
//            every max(div_active,1) running clocks, plus a blink square wave
//            (toggles per tick) and a wrapping tick counter.
// Ports    : clock        - rising-edge clock
//            reset_n      - asynchronous active-low reset
//            run          - count enable (low = pause, period resumes)
//            clear        - synchronous restart of period/blink/tick_count
//            div_load     - capture div_value as the next divisor
//            div_value    - divisor (0 behaves as 1)
//            enable_tick  - registered one-cycle pulse at end of each period
//            blink        - toggles on each tick
//            tick_count   - ticks since reset/clear, wraps
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module enable_generator
  import traffic_pkg::*;
#(
  parameter int          WIDTH       = DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = DIV_SIM,
  parameter int          CNT_WIDTH   = TICK_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic                 div_load,
  input  logic [WIDTH-1:0]     div_value,
  output logic                 enable_tick,
  output logic                 blink,
  output logic [CNT_WIDTH-1:0] tick_count
);

  logic [WIDTH-1:0]     cnt_q,           cnt_d;
  logic [WIDTH-1:0]     div_active_q,    div_active_d;
  logic [WIDTH-1:0]     div_pending_q,   div_pending_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 enable_tick_q,   enable_tick_d;
  logic                 blink_q,         blink_d;
  logic [CNT_WIDTH-1:0] tick_count_q,    tick_count_d;

  logic [WIDTH-1:0]     div_eff;
  logic [WIDTH-1:0]     div_next;
  logic                 wrap;

  // A zero divisor is stored as loaded but counts like 1.
  assign div_eff = (div_active_q == '0) ? WIDTH'(1) : div_active_q;
  assign wrap    = (cnt_q == div_eff - WIDTH'(1));

  // Divisor adopted at a period boundary: a same-cycle load beats an older
  // pending one, which beats keeping the current divisor.
  assign div_next = div_load        ? div_value     :
                    pending_valid_q ? div_pending_q : div_active_q;

  always_comb begin
    cnt_d           = cnt_q;
    div_active_d    = div_active_q;
    div_pending_d   = div_pending_q;
    pending_valid_d = pending_valid_q;
    enable_tick_d   = 1'b0;
    blink_d         = blink_q;
    tick_count_d    = tick_count_q;

    // Loads only stage the value; the running period is never disturbed.
    if (div_load) begin
      div_pending_d   = div_value;
      pending_valid_d = 1'b1;
    end

    if (clear) begin
      cnt_d           = '0;
      blink_d         = 1'b0;
      tick_count_d    = '0;
      div_active_d    = div_next;
      pending_valid_d = 1'b0;
    end else if (run) begin
      if (wrap) begin
        cnt_d           = '0;
        enable_tick_d   = 1'b1;
        blink_d         = ~blink_q;
        tick_count_d    = tick_count_q + CNT_WIDTH'(1);
        div_active_d    = div_next;
        pending_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q           <= '0;
      div_active_q    <= WIDTH'(DEFAULT_DIV);
      div_pending_q   <= '0;
      pending_valid_q <= 1'b0;
      enable_tick_q   <= 1'b0;
      blink_q         <= 1'b0;
      tick_count_q    <= '0;
    end else begin
      cnt_q           <= cnt_d;
      div_active_q    <= div_active_d;
      div_pending_q   <= div_pending_d;
      pending_valid_q <= pending_valid_d;
      enable_tick_q   <= enable_tick_d;
      blink_q         <= blink_d;
      tick_count_q    <= tick_count_d;
    end
  end

  assign enable_tick = enable_tick_q;
  assign blink       = blink_q;
  assign tick_count  = tick_count_q;

endmodule : enable_generator

`default_nettype wire

// File: tb/tb_enable_generator.sv
// ============================================================================
// Module   : tb_enable_generator
// Purpose  : Self-checking bench for enable_generator (WIDTH 27, divisor 10,
//            8-bit tick counter). A behavioural model pushes expected outputs
//            into a queue as each cycle is driven; they are popped and
//            compared after the clock edge. Tick positions are also checked
//            against hand-derived cycle numbers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_enable_generator;

  localparam int W  = 27;
  localparam int CW = 8;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          run      = 1'b0;
  logic          clear    = 1'b0;
  logic          div_load = 1'b0;
  logic [W-1:0]  div_value = '0;
  logic          enable_tick;
  logic          blink;
  logic [CW-1:0] tick_count;

  enable_generator #(
    .WIDTH      (W),
    .DEFAULT_DIV(10),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
    .clear      (clear),
    .div_load   (div_load),
    .div_value  (div_value),
    .enable_tick(enable_tick),
    .blink      (blink),
    .tick_count (tick_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          tick;
    logic          blink;
    logic [CW-1:0] tc;
  } exp_t;

  exp_t sb[$];
  int   tk[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   base     = 0;

  // Behavioural reference state
  int           m_cnt;
  logic [W-1:0] m_div;
  logic [W-1:0] m_pend;
  logic         m_pv;
  logic         m_tick;
  logic         m_blink;
  logic [CW-1:0] m_tc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_div = W'(10); m_pend = '0; m_pv = 1'b0;
    m_tick = 1'b0; m_blink = 1'b0; m_tc = '0;
  endtask

  task automatic model_step(input logic r, input logic c, input logic l, input logic [W-1:0] v);
    int           d;
    logic [W-1:0] sel;
    logic         applied;
    d       = (m_div == 0) ? 1 : int'(m_div);
    sel     = l ? v : (m_pv ? m_pend : m_div);
    applied = 1'b0;
    m_tick  = 1'b0;
    if (c) begin
      m_cnt = 0; m_blink = 1'b0; m_tc = '0; applied = 1'b1;
    end else if (r) begin
      if (m_cnt == d - 1) begin
        m_cnt = 0; m_tick = 1'b1; m_blink = ~m_blink; m_tc = m_tc + 1'b1; applied = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (l) m_pend = v;
    if (applied) begin
      m_div = sel; m_pv = 1'b0;
    end else if (l) begin
      m_pv = 1'b1;
    end
  endtask

  task automatic cycle(input logic r, input logic c, input logic l, input logic [W-1:0] v);
    exp_t e;
    run = r; clear = c; div_load = l; div_value = v;
    model_step(r, c, l, v);
    sb.push_back('{tick: m_tick, blink: m_blink, tc: m_tc});
    @(posedge clock);
    #1;
    cyc++;
    e = sb.pop_front();
    check("tick",       32'(enable_tick), 32'(e.tick));
    check("blink",      32'(blink),       32'(e.blink));
    check("tick_count", 32'(tick_count),  32'(e.tc));
    if (enable_tick === 1'b1) tk.push_back(cyc - base);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic start_scenario();
    tk.delete();
    base = cyc;
  endtask

  initial begin
    model_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_tick",  32'(enable_tick), 32'd0);
    check("rst_blink", 32'(blink),       32'd0);
    check("rst_tc",    32'(tick_count),  32'd0);
    reset_n = 1'b1;

    // Default divisor 10, continuous run.
    start_scenario();
    run_n(30);
    check("s1_ntick", 32'(tk.size()), 32'd3);
    check("s1_t0", 32'(tk[0]), 32'd10);
    check("s1_t1", 32'(tk[1]), 32'd20);
    check("s1_t2", 32'(tk[2]), 32'd30);

    // Load 4 at cnt=3: current period still ends at 10, then every 4.
    start_scenario();
    run_n(3);
    cycle(1'b1, 1'b0, 1'b1, W'(4));
    run_n(14);
    check("s2_ntick", 32'(tk.size()), 32'd3);
    check("s2_t0", 32'(tk[0]), 32'd10);
    check("s2_t1", 32'(tk[1]), 32'd14);
    check("s2_t2", 32'(tk[2]), 32'd18);

    // Restore 10 via clear+load, then pause 5 cycles at cnt=6.
    cycle(1'b0, 1'b1, 1'b1, W'(10));
    start_scenario();
    run_n(6);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    run_n(4);
    check("s3_ntick", 32'(tk.size()), 32'd1);
    check("s3_t0", 32'(tk[0]), 32'd15);

    // Clear at cnt=9 together with load of 3: no tick, next tick 3 later.
    start_scenario();
    run_n(9);
    cycle(1'b1, 1'b1, 1'b1, W'(3));
    check("s4_clr_blink", 32'(blink),      32'd0);
    check("s4_clr_tc",    32'(tick_count), 32'd0);
    run_n(3);
    check("s4_ntick", 32'(tk.size()), 32'd1);
    check("s4_t0", 32'(tk[0]), 32'd13);

    // Load 0 mid-period; after the wrap, tick every cycle; tick_count wraps.
    start_scenario();
    cycle(1'b1, 1'b0, 1'b1, W'(0));
    run_n(2);
    run_n(260);
    check("s5_ntick", 32'(tk.size()), 32'd261);
    check("s5_t0", 32'(tk[0]), 32'd3);

    // Asynchronous reset between edges, mid-period.
    cycle(1'b0, 1'b1, 1'b1, W'(10));
    run_n(15);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_tick",  32'(enable_tick), 32'd0);
    check("arst_blink", 32'(blink),       32'd0);
    check("arst_tc",    32'(tick_count),  32'd0);
    #1;
    reset_n = 1'b1;
    start_scenario();
    run_n(12);
    check("s6_ntick", 32'(tk.size()), 32'd1);
    check("s6_t0", 32'(tk[0]), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_enable_generator

`default_nettype wire
